// File: rtl/branch_predictor_param.sv
// branch_predictor_param: direct-mapped BTB with saturating direction counters.
//   Lookup (taken/select/nxtPC) is combinational from PC; table and stats update
//   on the rising CLK edge after a br strobe, with no bypass. No backpressure.
// Ports: CLK, nRST (sync, active-low) | PC -> taken, select, nxtPC (lookup)
//        br, br_result, brPC, braddr, br_pred (resolve/update)
//        pred_cnt, mispred_cnt (saturating statistics)
// Optional feature: define BP_GSHARE_EN to XOR a global history register into
// the low index bits of both lookup and update.
module branch_predictor_param #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 4,
  parameter int STAT_W   = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       PC,
  input  logic              br,
  input  logic              br_result,
  input  logic [31:0]       brPC,
  input  logic [31:0]       braddr,
  input  logic              br_pred,
  output logic              taken,
  output logic              select,
  output logic [31:0]       nxtPC,
  output logic [STAT_W-1:0] pred_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  logic [STAT_W-1:0]   pred_cnt_q, pred_cnt_d;
  logic [STAT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic [IDX-1:0]      lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                lk_hit, up_hit;
  logic [CTR_BITS-1:0] up_ctr, ctr_upd;

  // Byte-offset bits of the resolved address never affect the table.
  logic unused_bits;
  assign unused_bits = ^brPC[1:0];

  assign lk_tag = PC[31:IDX+2];
  assign up_tag = brPC[31:IDX+2];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  // Update uses the history as it was before this branch shifts in.
  assign lk_idx = PC[IDX+1:2]   ^ IDX'(ghr_q);
  assign up_idx = brPC[IDX+1:2] ^ IDX'(ghr_q);
  // Truncating cast drops the oldest bit; also valid when GHR_BITS == 1.
  assign ghr_d  = br ? GHR_BITS'({ghr_q, br_result}) : ghr_q;

  always_ff @(posedge CLK) begin
    if (!nRST) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  assign lk_idx = PC[IDX+1:2];
  assign up_idx = brPC[IDX+1:2];
`endif

  // Combinational lookup
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign taken  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign select = taken;
  assign nxtPC  = taken ? tgt_q[lk_idx] : (PC + 32'd4);

  // Update-side hit and saturating counter step
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr = ctr_q[up_idx];

  always_comb begin
    ctr_upd = up_ctr;
    if (br_result) begin
      if (up_ctr != CTR_MAX) ctr_upd = up_ctr + CTR_BITS'(1);
    end else begin
      if (up_ctr != '0)      ctr_upd = up_ctr - CTR_BITS'(1);
    end
  end

  always_comb begin
    pred_cnt_d    = pred_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (br) begin
      if (!(&pred_cnt_q)) pred_cnt_d = pred_cnt_q + STAT_W'(1);
      if ((br_pred != br_result) && !(&mispred_cnt_q))
        mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end
  end

  // Valid bits, counters and statistics (reset state)
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q       <= '0;
      pred_cnt_q    <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
    end else begin
      pred_cnt_q    <= pred_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (br) begin
        if (up_hit) begin
          ctr_q[up_idx] <= ctr_upd;
        end else if (br_result) begin
          valid_q[up_idx] <= 1'b1;
          ctr_q[up_idx]   <= CTR_WEAK;
        end
      end
    end
  end

  // Tags/targets carry no reset. A taken resolution writes both: on a hit
  // the tag is rewritten with its own value, on a miss it allocates.
  always_ff @(posedge CLK) begin
    if (nRST && br && br_result) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= braddr;
    end
  end

  assign pred_cnt    = pred_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_param.sv
// tb_branch_predictor_param: directed vector table, reset/saturation sequences
//   and a randomized run against a behavioural model of the predictor.
//   Statistics counters are built 4 bits wide so saturation is reachable.
module tb_branch_predictor_param;

  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [31:0]   PC, brPC, braddr;
  logic          br, br_result, br_pred;
  logic          taken, select;
  logic [31:0]   nxtPC;
  logic [SW-1:0] pred_cnt, mispred_cnt;

  branch_predictor_param #(
    .ENTRIES(16), .CTR_BITS(2), .GHR_BITS(4), .STAT_W(SW)
  ) dut (
    .CLK(CLK), .nRST(nRST), .PC(PC), .br(br), .br_result(br_result),
    .brPC(brPC), .braddr(braddr), .br_pred(br_pred), .taken(taken),
    .select(select), .nxtPC(nxtPC), .pred_cnt(pred_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input bit et, input logic [31:0] enx,
                         input int ep, input int em);
    chk({nm, ".taken"},   {31'b0, taken},  {31'b0, et});
    chk({nm, ".select"},  {31'b0, select}, {31'b0, et});
    chk({nm, ".nxtPC"},   nxtPC, enx);
    chk({nm, ".pred"},    32'(pred_cnt),    32'(ep));
    chk({nm, ".mispred"}, 32'(mispred_cnt), 32'(em));
  endtask

  // Behavioural model: a 16-slot table addressed by word address mod 16,
  // remembering the full upper address as the owner of each slot.
  bit          m_v   [16];
  logic [31:0] m_own [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  int          m_pred, m_mis;

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_v[slot(a)] && (m_own[slot(a)] == (a >> 6));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_v[i] = 0; m_ctr[i] = 0; end
    m_pred = 0; m_mis = 0;
  endtask

  task automatic model_resolve(input logic r, input logic [31:0] bpc,
                               input logic [31:0] badr, input logic bp);
    int s;
    s = slot(bpc);
    if (m_hit(bpc)) begin
      m_ctr[s] = r ? ((m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1)
                   : ((m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1);
      if (r) m_tgt[s] = badr;
    end else if (r) begin
      m_v[s] = 1; m_own[s] = bpc >> 6; m_tgt[s] = badr; m_ctr[s] = 2;
    end
    if (m_pred < SMAX) m_pred++;
    if (bp != r && m_mis < SMAX) m_mis++;
  endtask

  typedef struct {
    logic        b, r;
    logic [31:0] bpc, badr;
    logic        bp;
    logic [31:0] pc;
    bit          et;
    logic [31:0] enx;
    int          ep, em;
  } vec_t;

  vec_t vt[15];

  task automatic do_reset();
    nRST = 1'b0; br = 1'b0;
    @(posedge CLK); @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask

  initial begin
    nRST = 1'b0; PC = 32'h40; br = 0; br_result = 0; brPC = 0; braddr = 0; br_pred = 0;

    // Expected outputs are observed in the same cycle, before that cycle's update.
    //        br r  brPC          braddr        bp pc            tk nxtPC         pc mc
    vt[0]  = '{0, 0, 32'h0,        32'h0,        0, 32'h40,       0, 32'h44,       0, 0};
    vt[1]  = '{1, 1, 32'h40,       32'h100,      0, 32'h40,       0, 32'h44,       0, 0};
    vt[2]  = '{1, 0, 32'h40,       32'h0,        1, 32'h40,       1, 32'h100,      1, 1};
    vt[3]  = '{1, 0, 32'h40,       32'h0,        0, 32'h40,       0, 32'h44,       2, 2};
    vt[4]  = '{1, 0, 32'h40,       32'h0,        0, 32'h40,       0, 32'h44,       3, 2};
    vt[5]  = '{0, 0, 32'h0,        32'h0,        0, 32'h40,       0, 32'h44,       4, 2};
    vt[6]  = '{1, 1, 32'h40,       32'h104,      0, 32'h40,       0, 32'h44,       4, 2};
    vt[7]  = '{1, 1, 32'h40,       32'h108,      0, 32'h40,       0, 32'h44,       5, 3};
    vt[8]  = '{0, 0, 32'h0,        32'h0,        0, 32'h40,       1, 32'h108,      6, 4};
    vt[9]  = '{1, 1, 32'h80,       32'h200,      1, 32'h80,       0, 32'h84,       6, 4};
    vt[10] = '{0, 0, 32'h0,        32'h0,        0, 32'h40,       0, 32'h44,       7, 4};
    vt[11] = '{0, 0, 32'h0,        32'h0,        0, 32'h80,       1, 32'h200,      7, 4};
    vt[12] = '{0, 1, 32'h44,       32'h300,      0, 32'h44,       0, 32'h48,       7, 4};
    vt[13] = '{0, 0, 32'h0,        32'h0,        0, 32'h44,       0, 32'h48,       7, 4};
    vt[14] = '{0, 0, 32'h0,        32'h0,        0, 32'hFFFFFFFC, 0, 32'h00000000, 7, 4};

    @(negedge CLK);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      br = vt[i].b; br_result = vt[i].r; brPC = vt[i].bpc;
      braddr = vt[i].badr; br_pred = vt[i].bp; PC = vt[i].pc;
      #1 chk_out($sformatf("vec%0d", i), vt[i].et, vt[i].enx, vt[i].ep, vt[i].em);
      @(posedge CLK); @(negedge CLK);
    end
    br = 0;

    // A resolution coincident with reset is discarded; reset clears the table.
    nRST = 0; br = 1; br_result = 1; brPC = 32'h40; braddr = 32'h500; br_pred = 0;
    @(posedge CLK); @(negedge CLK);
    nRST = 1; br = 0; PC = 32'h40;
    #1 chk_out("rst_br_drop", 0, 32'h44, 0, 0);
    PC = 32'h80;
    #1 chk_out("rst_clears", 0, 32'h84, 0, 0);

    // 20 mispredicted not-taken misses: statistics saturate, table untouched.
    for (int i = 0; i < 20; i++) begin
      br = 1; br_result = 0; brPC = 32'h1000; br_pred = 1;
      @(posedge CLK); @(negedge CLK);
    end
    br = 0; PC = 32'h1000;
    #1 chk_out("stat_sat", 0, 32'h1004, SMAX, SMAX);

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      br        = ($urandom_range(0, 99) < 60);
      br_result = 1'($urandom);
      br_pred   = 1'($urandom);
      brPC      = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      braddr    = $urandom;
      PC        = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 49) == 0) PC = 32'hFFFFFFFC;
      #1;
      begin
        bit          et;
        logic [31:0] enx;
        et  = m_hit(PC) && (m_ctr[slot(PC)] >= 2);
        enx = et ? m_tgt[slot(PC)] : PC + 32'd4;
        chk_out($sformatf("rnd%0d", n), et, enx, m_pred, m_mis);
      end
      @(posedge CLK);
      if (br) model_resolve(br_result, brPC, braddr, br_pred);
      @(negedge CLK);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_param.md
BRANCH_PREDICTOR_PARAM -- requirements
Module: branch_predictor_param

Interface
REQ-001 SHALL provide parameter ENTRIES, default 16, meaning number of BTB entries (power of 2, 4..256); IDX = log2(ENTRIES).
REQ-002 SHALL provide parameter CTR_BITS, default 2, meaning saturating direction-counter width (2..4).
REQ-003 SHALL provide parameter GHR_BITS, default 4, meaning global history length (1..IDX).
REQ-004 SHALL provide parameter STAT_W, default 16, meaning width of each statistics counter.
REQ-005 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port nRST, input, 1, reset; it is synchronous and active-low.
REQ-007 SHALL have port PC, input, 32, fetch address being looked up.
REQ-008 SHALL have port br, input, 1, a branch resolved this cycle (update strobe).
REQ-009 SHALL have port br_result, input, 1, resolved direction (1 = taken).
REQ-010 SHALL have port brPC, input, 32, address of the resolved branch.
REQ-011 SHALL have port braddr, input, 32, resolved branch target.
REQ-012 SHALL have port br_pred, input, 1, direction that was predicted for the resolved branch.
REQ-013 SHALL have port taken, output, 1, predicted taken for PC.
REQ-014 SHALL have port select, output, 1, fetch should use nxtPC; equals taken.
REQ-015 SHALL have port nxtPC, output, 32, predicted next fetch address.
REQ-016 SHALL have port pred_cnt, output, STAT_W, branches resolved since reset.
REQ-017 SHALL have port mispred_cnt, output, STAT_W, direction mispredictions since reset.

Function
REQ-018 Each entry SHALL hold valid (1b), tag (PC[31:IDX+2]), target (32b), counter (CTR_BITS).
REQ-019 Lookup index SHALL be PC[IDX+1:2]; update index SHALL be brPC[IDX+1:2] (modified per REQ-031).
REQ-020 Lookup SHALL be combinational: hit = valid[idx] and tag match; taken = hit and counter MSB.
REQ-021 nxtPC SHALL be entry target when taken, else PC+4 (32-bit wrap-around).
REQ-022 On br with update-entry hit: counter SHALL increment if br_result, decrement otherwise, saturating at all-ones and zero.
REQ-023 On br with hit and br_result=1: target SHALL be overwritten with braddr.
REQ-024 On br with miss and br_result=1: entry SHALL be allocated: valid=1, tag from brPC, target=braddr, counter=weakly-taken (MSB 1, rest 0), replacing any prior occupant.
REQ-025 On br with miss and br_result=0: no table change.
REQ-026 Table update SHALL take effect the cycle after br; a same-cycle lookup of the updated index SHALL see pre-update contents (no bypass).
REQ-027 On br, pred_cnt SHALL increment by 1; mispred_cnt SHALL increment when br_pred != br_result; both saturate at all-ones.
REQ-028 Inputs br_result, brPC, braddr, br_pred SHALL be ignored when br=0.

Reset
REQ-029 With nRST low at a rising edge: all valid bits, counters, GHR, pred_cnt, mispred_cnt SHALL clear to 0; tags/targets need not reset.
REQ-030 After reset taken=0, select=0, nxtPC=PC+4; a br coincident with nRST low SHALL be discarded.

Configuration
REQ-031 Macro BP_GSHARE_EN SHALL, when defined, add a GHR_BITS global history register shifted left with br_result on each br, and XOR its value into the low GHR_BITS of both lookup and update index (update uses the pre-shift GHR); tag compare unchanged.
REQ-032 Without BP_GSHARE_EN no GHR SHALL exist and indexing SHALL be pure PC bits per REQ-019.

Verification
REQ-033 Reset, PC=0x40 -> taken=0, select=0, nxtPC=0x44, pred_cnt=0.
REQ-034 br=1, brPC=0x40, br_result=1, braddr=0x100, br_pred=0; next cycle PC=0x40 -> taken=1, nxtPC=0x100, mispred_cnt=1.
REQ-035 Then two not-taken resolutions of 0x40 -> counter 01 then 00; lookup 0x40 -> taken=0 after first; a third not-taken keeps counter 00; pred_cnt=4.
REQ-036 Aliasing (ENTRIES=16): allocate 0x40 taken, then allocate 0x80 taken (same index) -> lookup 0x40 misses (nxtPC=0x44), lookup 0x80 hits target.
REQ-037 Same-cycle br to 0x40 and lookup PC=0x40 on empty table -> taken=0 that cycle, taken=1 next cycle; STAT_W=4 with 20 mispredicts -> mispred_cnt=15.
REQ-038 With BP_GSHARE_EN: resolve 0x40 taken twice (GHR 0000->0001->0011) -> entries written at indices 0 and 1; lookup 0x40 with GHR=0011 uses index 3 and misses.
